// File: rtl/rti_sequencer_pkg.sv
// Shared processor constants: RTI sequencer state encoding, pop-target selects and
// the stack opcodes the interrupt and RTI sequencers inject into the pipeline.
package rti_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STALL   = 3'd1,
    ST_POP_PCH = 3'd2,
    ST_POP_PCL = 3'd3,
    ST_POP_CCR = 3'd4,
    ST_WAIT    = 3'd5,
    ST_PC_LOAD = 3'd6
  } rti_state_e;

  localparam logic [1:0] SEL_PCL = 2'b00;
  localparam logic [1:0] SEL_PCH = 2'b01;
  localparam logic [1:0] SEL_CCR = 2'b10;

  localparam logic [15:0] OP_NOP     = 16'h0000;
  localparam logic [15:0] OP_POP_PCL = 16'h6808;
  localparam logic [15:0] OP_POP_PCH = 16'h6809;
  localparam logic [15:0] OP_POP_CCR = 16'h680A;

  // Interrupt entry pushes CCR, PCL, PCH; RTI pops in the reverse order.
  localparam logic [15:0] OP_PSH_PCL = 16'h6800;
  localparam logic [15:0] OP_PSH_PCH = 16'h6801;
  localparam logic [15:0] OP_PSH_CCR = 16'h6802;

endpackage

// File: rtl/rti_sequencer.sv
// Return-from-interrupt sequencer: stalls fetch, injects POP PCH/PCL/CCR, waits for the
// PC halves to retire from write-back, then strobes the return address into the PC.
module rti_sequencer
  import rti_sequencer_pkg::*;
#(
  parameter int WAIT_LIMIT = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rti_detect,
  input  logic        pop_valid,
  input  logic [1:0]  pop_sel,
  input  logic [15:0] pop_data,
  output logic        pc_stop,
  output logic [15:0] instruction,
  output logic        pc_change,
  output logic [31:0] pc_value,
  output logic        int_block,
  output logic        rti_err
);

  localparam logic [2:0] LAST_WAIT = 3'(WAIT_LIMIT - 1);

  rti_state_e  state_q, state_d;
  logic [15:0] pch_q, pch_d;
  logic [15:0] pcl_q, pcl_d;
  logic        have_pch_q, have_pch_d;
  logic        have_pcl_q, have_pcl_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        cap_pch, cap_pcl;

  assign cap_pch = (state_q != ST_IDLE) && pop_valid && (pop_sel == SEL_PCH);
  assign cap_pcl = (state_q != ST_IDLE) && pop_valid && (pop_sel == SEL_PCL);

  always_comb begin
    state_d    = state_q;
    pch_d      = pch_q;
    pcl_d      = pcl_q;
    have_pch_d = have_pch_q;
    have_pcl_d = have_pcl_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;

    if (cap_pch) begin
      pch_d      = pop_data;
      have_pch_d = 1'b1;
    end
    if (cap_pcl) begin
      pcl_d      = pop_data;
      have_pcl_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rti_detect) begin
          state_d    = ST_STALL;
          have_pch_d = 1'b0;
          have_pcl_d = 1'b0;
        end
      end
      ST_STALL:   state_d = ST_POP_PCH;
      ST_POP_PCH: state_d = ST_POP_PCL;
      ST_POP_PCL: state_d = ST_POP_CCR;
      ST_POP_CCR: begin
        state_d = ST_WAIT;
        cnt_d   = 3'd0;
      end
      ST_WAIT: begin
        // A capture landing this cycle counts, so the flags are tested after update.
        if (have_pch_d && have_pcl_d) begin
          state_d = ST_PC_LOAD;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_PC_LOAD: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Disable outranks reset; neither lets a pending PC load escape.
    if (!enable) begin
      state_d    = ST_IDLE;
      have_pch_d = 1'b0;
      have_pcl_d = 1'b0;
      cnt_d      = 3'd0;
      err_d      = 1'b0;
    end else if (!reset) begin
      state_d    = ST_IDLE;
      pch_d      = 16'h0000;
      pcl_d      = 16'h0000;
      have_pch_d = 1'b0;
      have_pcl_d = 1'b0;
      cnt_d      = 3'd0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    pch_q      <= pch_d;
    pcl_q      <= pcl_d;
    have_pch_q <= have_pch_d;
    have_pcl_q <= have_pcl_d;
    cnt_q      <= cnt_d;
    err_q      <= err_d;
  end

  always_comb begin
    pc_stop     = (state_q != ST_IDLE);
    int_block   = (state_q != ST_IDLE);
    pc_change   = (state_q == ST_PC_LOAD);
    pc_value    = (state_q == ST_PC_LOAD) ? {pch_q, pcl_q} : 32'h0000_0000;
    rti_err     = err_q;
    instruction = OP_NOP;
    case (state_q)
      ST_POP_PCH: instruction = OP_POP_PCH;
      ST_POP_PCL: instruction = OP_POP_PCL;
      ST_POP_CCR: instruction = OP_POP_CCR;
      default:    instruction = OP_NOP;
    endcase
  end

endmodule

// File: tb/tb_rti_sequencer.sv
// Bench for rti_sequencer: directed vector table, corner-case sequences and random
// stimulus, all compared against a cycle-position reference model.
module tb_rti_sequencer;

  localparam int LIMIT = 7;

  logic        clk = 1'b0;
  logic        reset, enable, rti_detect, pop_valid;
  logic [1:0]  pop_sel;
  logic [15:0] pop_data;
  logic        pc_stop, pc_change, int_block, rti_err;
  logic [15:0] instruction;
  logic [31:0] pc_value;

  always #5 clk = ~clk;

  rti_sequencer #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rti_detect(rti_detect),
    .pop_valid(pop_valid), .pop_sel(pop_sel), .pop_data(pop_data),
    .pc_stop(pc_stop), .instruction(instruction), .pc_change(pc_change),
    .pc_value(pc_value), .int_block(int_block), .rti_err(rti_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_pos is the cycle position inside a sequence (0 idle, 1 stall,
  // 2..4 the three pops, 5 waiting for retirement, 6 PC load).
  int          m_pos   = 0;
  int          m_waits = 0;
  logic [15:0] m_pch   = 16'h0;
  logic [15:0] m_pcl   = 16'h0;
  logic        m_gh = 1'b0, m_gl = 1'b0, m_err = 1'b0;

  wire [51:0] dut_out = {pc_stop, instruction, pc_change, pc_value, int_block, rti_err};

  function automatic logic [51:0] mk(logic stop, logic [15:0] ins, logic chg,
                                     logic [31:0] val, logic blk, logic err);
    return {stop, ins, chg, val, blk, err};
  endfunction

  function automatic logic [51:0] model_out();
    logic [15:0] ins;
    ins = (m_pos == 2) ? 16'h6809 : (m_pos == 3) ? 16'h6808 :
          (m_pos == 4) ? 16'h680A : 16'h0000;
    return mk(m_pos != 0, ins, m_pos == 6, (m_pos == 6) ? {m_pch, m_pcl} : 32'h0,
              m_pos != 0, m_err);
  endfunction

  task automatic model_step();
    if (!enable || !reset) begin
      m_pos = 0; m_waits = 0; m_gh = 1'b0; m_gl = 1'b0; m_err = 1'b0;
      if (enable) begin m_pch = 16'h0; m_pcl = 16'h0; end
    end else begin
      m_err = 1'b0;
      if (m_pos != 0 && pop_valid && pop_sel == 2'b01) begin m_pch = pop_data; m_gh = 1'b1; end
      if (m_pos != 0 && pop_valid && pop_sel == 2'b00) begin m_pcl = pop_data; m_gl = 1'b1; end
      case (m_pos)
        0: if (rti_detect) begin m_pos = 1; m_gh = 1'b0; m_gl = 1'b0; end
        1, 2, 3: m_pos = m_pos + 1;
        4: begin m_pos = 5; m_waits = 0; end
        5: begin
          m_waits = m_waits + 1;
          if (m_gh && m_gl) m_pos = 6;
          else if (m_waits == LIMIT) begin m_pos = 0; m_err = 1'b1; end
        end
        default: m_pos = 0;
      endcase
    end
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic rst, input logic det,
                       input logic pv, input logic [1:0] ps, input logic [15:0] pd);
    enable = en; reset = rst; rti_detect = det; pop_valid = pv; pop_sel = ps; pop_data = pd;
  endtask

  task automatic cycle(input string name);
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp(name, 64'(dut_out), 64'(model_out()));
  endtask

  typedef struct {
    logic        en, rst, det, pv;
    logic [1:0]  ps;
    logic [15:0] pd;
    logic [51:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int err_at, chg_cnt;
    logic stop7, stop8, chg6, blk6;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0);
    @(negedge clk);

    // Nominal RTI: pops PCH=0001 then PCL=2345 two cycles later.
    tbl[0] = '{1, 0, 0, 0, 2'b00, 16'h0000, mk(0, 16'h0000, 0, 32'h0, 0, 0)};
    tbl[1] = '{1, 1, 1, 0, 2'b00, 16'h0000, mk(1, 16'h0000, 0, 32'h0, 1, 0)};
    tbl[2] = '{1, 1, 0, 0, 2'b00, 16'h0000, mk(1, 16'h6809, 0, 32'h0, 1, 0)};
    tbl[3] = '{1, 1, 0, 1, 2'b01, 16'h0001, mk(1, 16'h6808, 0, 32'h0, 1, 0)};
    tbl[4] = '{1, 1, 0, 0, 2'b00, 16'h0000, mk(1, 16'h680A, 0, 32'h0, 1, 0)};
    tbl[5] = '{1, 1, 0, 1, 2'b00, 16'h2345, mk(1, 16'h0000, 0, 32'h0, 1, 0)};
    tbl[6] = '{1, 1, 0, 0, 2'b00, 16'h0000, mk(1, 16'h0000, 1, 32'h00012345, 1, 0)};
    tbl[7] = '{1, 1, 0, 0, 2'b00, 16'h0000, mk(0, 16'h0000, 0, 32'h0, 0, 0)};
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].rst, tbl[i].det, tbl[i].pv, tbl[i].ps, tbl[i].pd);
      cycle("nominal_model");
      cmp($sformatf("nominal_row%0d", i), 64'(dut_out), 64'(tbl[i].exp));
    end

    // Timeout: only PCH retires; error pulse follows the seventh WAIT cycle.
    err_at = 0; chg_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      drive(1'b1, 1'b1, k == 1, k == 3, 2'b01, 16'hBEEF);
      cycle("timeout_model");
      if (rti_err) err_at = k;
      if (pc_change) chg_cnt++;
    end
    cmp("timeout_err_cycle", 64'(err_at), 64'd12);
    cmp("timeout_no_change", 64'(chg_cnt), 64'd0);

    // Reset asserted while in POP_PCL.
    chg_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, k != 4, k == 1, k == 3, 2'b01, 16'h1111);
      cycle("reset_midop_model");
      if (k == 4) cmp("reset_midop_stop", 64'(pc_stop), 64'd0);
      if (pc_change) chg_cnt++;
    end
    cmp("reset_midop_no_change", 64'(chg_cnt), 64'd0);

    // Detect held high: one full sequence, then a fresh start from IDLE.
    chg_cnt = 0; stop7 = 1'b1; stop8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b1, 1'b1, k == 3 || k == 5, (k == 3) ? 2'b01 : 2'b00,
            (k == 3) ? 16'hABCD : 16'h0042);
      cycle("retrigger_model");
      if (k <= 7 && pc_change) chg_cnt++;
      if (k == 7) stop7 = pc_stop;
      if (k == 8) stop8 = pc_stop;
    end
    cmp("retrigger_one_load", 64'(chg_cnt), 64'd1);
    cmp("retrigger_idle_gap", 64'(stop7), 64'd0);
    cmp("retrigger_restart", 64'(stop8), 64'd1);
    for (int k = 0; k < 14; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
      cycle("retrigger_drain_model");
    end

    // PCL retires in the first WAIT cycle: PC_LOAD on the very next edge.
    chg6 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      drive(1'b1, 1'b1, k == 1, k == 3 || k == 6, (k == 3) ? 2'b01 : 2'b00,
            (k == 3) ? 16'h00FE : 16'hCAFE);
      cycle("samecycle_model");
      if (k == 6) chg6 = pc_change;
      if (k == 6) cmp("samecycle_value", 64'(pc_value), 64'h00FECAFE);
    end
    cmp("samecycle_load", 64'(chg6), 64'd1);

    // Disable during WAIT.
    blk6 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(k != 6, 1'b1, k == 1, k == 3, 2'b01, 16'h7777);
      cycle("disable_model");
      if (k == 6) blk6 = int_block;
    end
    cmp("disable_int_block", 64'(blk6), 64'd0);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      drive($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 97,
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 40,
            2'($urandom_range(0, 3)), 16'($urandom));
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
